// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the in-order RV32I pipeline.
// Merges load-use, EX busy, multi-cycle EX ops, branch redirect and MEM exceptions.
module pipe_hazard_ctrl #(
    parameter int NSTAGE  = 6,
    parameter int ID_IDX  = 2,
    parameter int EX_IDX  = 3,
    parameter int MEM_IDX = 4,
    parameter int CNTW    = 6,
    parameter int PERFW   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              mc_start,
    input  logic [CNTW-1:0]   mc_cycles,
    input  logic              flush_br,
    input  logic              excp_req,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              mc_busy,
    output logic [PERFW-1:0]  perf_stall_cnt
);

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MC_WAIT = 1'b1;

    logic [0:0]      state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;

    // Contiguous prefix: bits [k:0] set.
    function automatic logic [NSTAGE-1:0] stall_to(input int unsigned k);
        logic [NSTAGE-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NSTAGE; i++)
            if (i <= k) m[i] = 1'b1;
        return m;
    endfunction

    // Bits [k:1] set; the PC is never flushed.
    function automatic logic [NSTAGE-1:0] flush_to(input int unsigned k);
        logic [NSTAGE-1:0] m;
        m = '0;
        for (int unsigned i = 1; i < NSTAGE; i++)
            if (i <= k) m[i] = 1'b1;
        return m;
    endfunction

    always_comb begin
        stall     = '0;
        flush     = '0;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (rst_n) begin
            if (state == RUN) begin
                if (excp_req) begin
                    flush = flush_to(MEM_IDX);
                end else if (mc_start && mc_cycles >= CNTW'(2)) begin
                    stall = stall_to(EX_IDX);
                    if (mc_cycles > CNTW'(2)) begin
                        cnt_nxt   = mc_cycles - CNTW'(2);
                        state_nxt = MC_WAIT;
                    end
                end else if (stallreq_ex) begin
                    stall = stall_to(EX_IDX);
                end else if (flush_br) begin
                    flush = flush_to(ID_IDX);
                end else if (stallreq_id) begin
                    stall = stall_to(ID_IDX);
                end
            end else begin
                if (excp_req) begin
                    flush     = flush_to(MEM_IDX);
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end else begin
                    stall   = stall_to(EX_IDX);
                    cnt_nxt = cnt - CNTW'(1);
                    if (cnt == CNTW'(1)) state_nxt = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= RUN;
            cnt            <= '0;
            perf_stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stall[0] && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + PERFW'(1);
        end
    end

    assign mc_busy = (state == MC_WAIT);

endmodule
